regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two write-back requesters.
  - Requester A: the pipeline write-back stage.
  - Requester B: the load/IO return path.
- Arbitration is fixed-priority with a starvation guard. The winning write is registered and driven onto the register file's write port.
- Also produces a hazard flag for the decode stage when a read address matches a pending or in-flight write.
- Sits between the pipeline write-back stage and regfile write inputs (we, writeaddr, writedata).

---
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, the register file and decode.
// WB_FWD_EN adds the forwarding outputs.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [ADDR_W-1:0] chk_addr1;
   logic [ADDR_W-1:0] chk_addr2;
   logic              hazard;
   logic [7:0]        drop_cnt;
`ifdef WB_FWD_EN
   logic              fwd_hit1;
   logic              fwd_hit2;
   logic [DATA_W-1:0] fwd_data1;
   logic [DATA_W-1:0] fwd_data2;
`endif

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      output chk_addr1, chk_addr2,
      input  a_ready, b_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  hazard, drop_cnt
`ifdef WB_FWD_EN
      , input fwd_hit1, fwd_hit2
      , input fwd_data1, fwd_data2
`endif
   );

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      input  chk_addr1, chk_addr2,
      output a_ready, b_ready,
      output rf_we, rf_waddr, rf_wdata,
      output hazard, drop_cnt
`ifdef WB_FWD_EN
      , output fwd_hit1, fwd_hit2
      , output fwd_data1, fwd_data2
`endif
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Fixed-priority register-file write-port arbiter with starvation guard.
// Optional WB_FWD_EN: forward the in-flight write to decode instead of stalling.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 3
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   logic [3:0]        starve_q, starve_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        drop_q, drop_d;

   logic              b_win, a_gnt, b_gnt, gnt;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;

   // B takes the port when alone or once it has waited STARVE_MAX cycles
   assign b_win = bus.b_valid
               && (!bus.a_valid || starve_q == SMAX);
   assign a_gnt = !rst && bus.a_valid && !b_win;
   assign b_gnt = !rst && b_win;
   assign gnt   = a_gnt || b_gnt;
   assign g_addr = b_gnt ? bus.b_addr : bus.a_addr;
   assign g_data = b_gnt ? bus.b_data : bus.a_data;

   assign bus.a_ready  = a_gnt;
   assign bus.b_ready  = b_gnt;
   assign bus.rf_we    = we_q;
   assign bus.rf_waddr = waddr_q;
   assign bus.rf_wdata = wdata_q;
   assign bus.drop_cnt = drop_q;

   always_comb begin
      starve_d = 4'd0;
      if (bus.b_valid && !b_gnt)
         starve_d = (starve_q == SMAX) ? SMAX
                                        : starve_q + 4'd1;
   end

   always_comb begin
      we_d    = gnt && (g_addr != '0);
      waddr_d = we_d ? g_addr : waddr_q;
      wdata_d = we_d ? g_data : wdata_q;
      drop_d  = drop_q;
      if (gnt && g_addr == '0 && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= 4'd0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         drop_q   <= 8'd0;
      end else begin
         starve_q <= starve_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         drop_q   <= drop_d;
      end
   end

   logic pend1, pend2, fly1, fly2;

   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      fly1  = 1'b0;
      fly2  = 1'b0;
      if (bus.chk_addr1 != '0) begin
         pend1 = (bus.a_valid && bus.a_addr == bus.chk_addr1)
              || (bus.b_valid && bus.b_addr == bus.chk_addr1);
         fly1  = we_q && waddr_q == bus.chk_addr1;
      end
      if (bus.chk_addr2 != '0) begin
         pend2 = (bus.a_valid && bus.a_addr == bus.chk_addr2)
              || (bus.b_valid && bus.b_addr == bus.chk_addr2);
         fly2  = we_q && waddr_q == bus.chk_addr2;
      end
   end

`ifdef WB_FWD_EN
   assign bus.hazard    = pend1 || pend2;
   assign bus.fwd_hit1  = fly1;
   assign bus.fwd_hit2  = fly2;
   assign bus.fwd_data1 = wdata_q;
   assign bus.fwd_data2 = wdata_q;
`else
   assign bus.hazard = pend1 || pend2 || fly1 || fly2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued on grant,
// a negedge monitor pops and compares each register-file write.
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;
   logic exp_we = 1'b0;
   logic [36:0] sb[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_wb_arbiter #(
      .DATA_W(32), .ADDR_W(5), .STARVE_MAX(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // monitor: every register-file write must match the next queued grant
   always @(negedge clk) begin
      if (bus.rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL rf_write: got %0h:%0h expected none",
                     bus.rf_waddr, bus.rf_wdata);
         end else begin
            logic [36:0] e;
            e = sb.pop_front();
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(e[36:32]));
            chk("rf_wdata", bus.rf_wdata, e[31:0]);
         end
      end
   end

   task automatic step(input logic av, input logic [4:0] aa,
                       input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba,
                       input logic [31:0] bd,
                       input logic era, input logic erb);
      @(negedge clk);
      chk("rf_we", 32'(bus.rf_we), 32'(exp_we));
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
      #1;
      chk("a_ready", 32'(bus.a_ready), 32'(era));
      chk("b_ready", 32'(bus.b_ready), 32'(erb));
      exp_we = 1'b0;
      if (era && aa != 0) begin
         sb.push_back({aa, ad}); exp_we = 1'b1;
      end
      if (erb && ba != 0) begin
         sb.push_back({ba, bd}); exp_we = 1'b1;
      end
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_hz_fly;
`ifdef WB_FWD_EN
      exp_hz_fly = 1'b0;
`else
      exp_hz_fly = 1'b1;
`endif
      bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h55;
      bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'h0;
      bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
      chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst_wdata", bus.rf_wdata, 32'd0);
      chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_a_ready", 32'(bus.a_ready), 32'd1);
      sb.push_back({5'd3, 32'h55});
      exp_we = 1'b1;

      step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      idle();
      idle();

      bus.chk_addr1 = 5'd9;
      step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      chk("hazard_pend_a", 32'(bus.hazard), 32'd1);
      idle();
      chk("hazard_fly9", 32'(bus.hazard), 32'(exp_hz_fly));
      bus.chk_addr1 = 5'd0;
      step(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      chk("hazard_r0", 32'(bus.hazard), 32'd0);
      idle();
      chk("drop_a0", 32'(bus.drop_cnt), 32'd1);

      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b1);
      idle();
      chk("drop_b0", 32'(bus.drop_cnt), 32'd2);

      step(1'b1, 5'd7, 32'hABCD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      idle();
      bus.chk_addr2 = 5'd7;
      #1;
      chk("hazard_fly7", 32'(bus.hazard), 32'(exp_hz_fly));
`ifdef WB_FWD_EN
      chk("fwd_hit2", 32'(bus.fwd_hit2), 32'd1);
      chk("fwd_data2", bus.fwd_data2, 32'hABCD);
      chk("fwd_hit1", 32'(bus.fwd_hit1), 32'd0);
`endif
      bus.chk_addr2 = 5'd0;

      bus.chk_addr1 = 5'd11;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 5'd10, 32'h100 + 32'(i),
              1'b1, 5'd11, 32'h200 + 32'(i / 4),
              (i % 4) != 3, (i % 4) == 3);
         if (i == 0) chk("hazard_pend_b", 32'(bus.hazard), 32'd1);
      end
      bus.chk_addr1 = 5'd0;
      idle();
      idle();

      for (int i = 0; i < 256; i++)
         step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'(i), 1'b0, 1'b1);
      idle();
      chk("drop_sat", 32'(bus.drop_cnt), 32'd255);
      idle();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
